// File: rtl/wb_copy_engine.sv
// Wishbone pipelined master that copies a block of words between RAM regions,
// one read followed by one write per word, over a single memory port.
module wb_copy_engine #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_done,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic [SEL_WIDTH-1:0]  wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_stall_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH
  } state_t;

  localparam logic [ADDR_WIDTH:0] LenOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [ADDR_WIDTH:0]   remain_q, words_q;
  logic [DATA_WIDTH-1:0] buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A stalled request simply stays in its REQ state, which keeps every bus
  // output stable because they are all decoded from registers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = (cmd_len == '0) ? FINISH : RD_REQ;
      RD_REQ:  if (!wb_stall_i) state_d = RD_WAIT;
      RD_WAIT: if (wb_ack_i) state_d = WR_REQ;
      WR_REQ:  if (!wb_stall_i) state_d = WR_WAIT;
      WR_WAIT: if (wb_ack_i) state_d = (remain_q == LenOne) ? FINISH : RD_REQ;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      remain_q <= '0;
      words_q  <= '0;
      buf_q    <= '0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        src_q    <= cmd_src;
        dst_q    <= cmd_dst;
        remain_q <= cmd_len;
        words_q  <= '0;
      end
      if (state_q == RD_WAIT && wb_ack_i) buf_q <= wb_data_i;
      // Address increments wrap naturally at the register width.
      if (state_q == WR_WAIT && wb_ack_i) begin
        src_q    <= src_q + 1'b1;
        dst_q    <= dst_q + 1'b1;
        words_q  <= words_q + LenOne;
        remain_q <= remain_q - LenOne;
      end
    end
  end

  always_comb begin
    wb_stb_o  = (state_q == RD_REQ) || (state_q == WR_REQ);
    wb_we_o   = (state_q == WR_REQ);
    wb_addr_o = '0;
    wb_data_o = '0;
    if (state_q == RD_REQ) wb_addr_o = src_q;
    if (state_q == WR_REQ) begin
      wb_addr_o = dst_q;
      wb_data_o = buf_q;
    end
    wb_sel_o   = wb_stb_o ? {SEL_WIDTH{1'b1}} : {SEL_WIDTH{1'b0}};
    cmd_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    done       = (state_q == FINISH);
    words_done = words_q;
  end

endmodule

// File: tb/tb_wb_copy_engine.sv
// Bench for wb_copy_engine: a Wishbone RAM slave with optional stall, and a
// scoreboard of expected bus transactions built when each command is issued.
module tb_wb_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_src, cmd_dst;
  logic [9:0]  cmd_len;
  logic        busy, done;
  logic [9:0]  words_done;
  logic [8:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o;
  logic        wb_ack_i;
  logic        wb_stall_i;
  logic [31:0] wb_data_i;

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];
  logic        load_req;
  logic        stall_en;
  int          stall_ph;
  int          stall_cycles;
  int          checks;
  int          failures;

  wb_copy_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .busy(busy), .done(done), .words_done(words_done),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i), .wb_data_i(wb_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [8:0] a);
    logic [31:0] v;
    if (a < 9'd4) v = 32'h11111111 * (32'(a) + 32'd1);
    else          v = {16'hC0DE, 7'd0, a};
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // RAM slave: accepts when stb && !stall, acks with data one cycle later.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_val(9'(i));
    end else if (rst_n && wb_stb_o && !wb_stall_i) begin
      if (wb_we_o) mem[wb_addr_o] <= wb_data_o;
      wb_data_i <= mem[wb_addr_o];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_ack_i <= 1'b0;
    else        wb_ack_i <= wb_stb_o && !wb_stall_i;
  end

  // Stall pattern stands in for a competing port: blocks two of every three cycles.
  always begin
    @(posedge clk);
    #1;
    stall_ph   = stall_ph + 1;
    wb_stall_i = stall_en && (stall_ph % 3 != 0);
  end

  // Monitor: every strobed cycle must match the queue head; pop only on acceptance.
  always @(negedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(9'(i));
    end
    if (!rst_n) begin
      exp_q.delete();
    end else if (wb_stb_o) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_stb", 64'(wb_stb_o), 64'd0);
      end else begin
        checkOutput("txn_we", 64'(wb_we_o), 64'(exp_q[0].we));
        checkOutput("txn_addr", 64'(wb_addr_o), 64'(exp_q[0].addr));
        checkOutput("txn_sel", 64'(wb_sel_o), 64'hF);
        if (exp_q[0].we) checkOutput("txn_data", 64'(wb_data_o), 64'(exp_q[0].data));
        if (wb_stall_i) begin
          stall_cycles++;
        end else begin
          if (exp_q[0].we) ref_mem[exp_q[0].addr] = exp_q[0].data;
          void'(exp_q.pop_front());
        end
      end
    end else begin
      checkOutput("sel_idle", 64'(wb_sel_o), 64'd0);
    end
  end

  task automatic applyStimulus(input logic [8:0] src, input logic [8:0] dst,
                               input logic [9:0] len);
    logic [8:0] s, d;
    @(negedge clk);
    checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int k = 0; k < int'(len); k++) begin
      s = src + 9'(k);
      d = dst + 9'(k);
      exp_q.push_back('{we: 1'b0, addr: s, data: 32'd0});
      exp_q.push_back('{we: 1'b1, addr: d, data: ref_mem[s]});
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Called at accept edge + 1. Done is visible right after edge N+4L(+stalls),
  // i.e. in cycle 4L+1 counting the accept cycle.
  task automatic wait_done(input int len, input bit inject);
    int k  = 0;
    int s0 = stall_cycles;
    while (!done && k < 400) begin
      if (inject && k == 5) begin
        checkOutput("busy_reject_ready", 64'(cmd_ready), 64'd0);
        cmd_src   = 9'h000;
        cmd_dst   = 9'h180;
        cmd_len   = 10'd1;
        cmd_valid = 1'b1;
      end
      if (inject && k == 6) cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      k++;
    end
    cmd_valid = 1'b0;
    checkOutput("done_seen", 64'(done), 64'd1);
    if (done) begin
      checkOutput("done_latency", 64'(k), 64'(4 * len + (stall_cycles - s0)));
      checkOutput("busy_at_done", 64'(busy), 64'd1);
      checkOutput("words_done", 64'(words_done), 64'(len));
    end
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", 64'(done), 64'd0);
    checkOutput("busy_after", 64'(busy), 64'd0);
    checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int          k;
    int          s0;
    logic [8:0]  a;
    checks = 0; failures = 0; stall_cycles = 0; stall_ph = 0;
    rst_n = 1'b0; load_req = 1'b1; stall_en = 1'b0; wb_stall_i = 1'b0;
    cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_words_done", 64'(words_done), 64'd0);
    checkOutput("rst_bus", 64'({wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o}), 64'd0);
    checkOutput("rst_wdata", 64'(wb_data_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;

    $display("[TB] basic copy");
    applyStimulus(9'h000, 9'h100, 10'd4);
    wait_done(4, 1'b0);
    for (int i = 0; i < 4; i++)
      checkOutput("basic_mem", 64'(mem[9'h100 + 9'(i)]), 64'(32'h11111111 * (i + 1)));

    $display("[TB] stall arbitration");
    s0 = stall_cycles;
    stall_en = 1'b1;
    applyStimulus(9'h010, 9'h020, 10'd2);
    wait_done(2, 1'b0);
    stall_en = 1'b0;
    checkOutput("stall_seen", 64'(stall_cycles > s0), 64'd1);
    for (int i = 0; i < 2; i++)
      checkOutput("stall_mem", 64'(mem[9'h020 + 9'(i)]), 64'(init_val(9'h010 + 9'(i))));

    $display("[TB] wrap-around");
    applyStimulus(9'h1FE, 9'h0F0, 10'd4);
    wait_done(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = 9'h1FE + 9'(i);
      checkOutput("wrap_mem", 64'(mem[9'h0F0 + 9'(i)]), 64'(init_val(a)));
    end

    $display("[TB] zero length");
    applyStimulus(9'h030, 9'h150, 10'd0);
    wait_done(0, 1'b0);
    checkOutput("zero_mem", 64'(mem[9'h150]), 64'(init_val(9'h150)));

    $display("[TB] busy rejection");
    applyStimulus(9'h040, 9'h060, 10'd3);
    wait_done(3, 1'b1);
    checkOutput("reject_mem180", 64'(mem[9'h180]), 64'(init_val(9'h180)));
    for (int i = 0; i < 3; i++)
      checkOutput("reject_copy", 64'(mem[9'h060 + 9'(i)]), 64'(init_val(9'h040 + 9'(i))));

    $display("[TB] reset mid-operation");
    applyStimulus(9'h080, 9'h0A0, 10'd4);
    k = 0;
    while (!(wb_stb_o && wb_we_o && words_done == 10'd1) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("reach_wr_word1", 64'(wb_stb_o && wb_we_o), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_stb", 64'(wb_stb_o), 64'd0);
    checkOutput("abort_idle", 64'(cmd_ready), 64'd1);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("abort_word0", 64'(mem[9'h0A0]), 64'(init_val(9'h080)));
    checkOutput("abort_word1", 64'(mem[9'h0A1]), 64'(init_val(9'h0A1)));
    applyStimulus(9'h081, 9'h0A1, 10'd1);
    wait_done(1, 1'b0);
    checkOutput("post_reset_copy", 64'(mem[9'h0A1]), 64'(init_val(9'h081)));
    checkOutput("post_reset_word2", 64'(mem[9'h0A2]), 64'(init_val(9'h0A2)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
